sig_edge_monitor: RTL and testbench

SIG_EDGE_MONITOR -- requirements
Module: sig_edge_monitor

---
 rtl/sig_mon_pkg.sv | 7 +
 rtl/sat_counter.sv | 21 ++
 rtl/sig_edge_monitor.sv | 63 ++++++
 tb/tb_sig_edge_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sig_mon_pkg.sv
// sig_mon_pkg: FSM state encoding and default sizes shared by sig_edge_monitor and its counters
package sig_mon_pkg;
    typedef enum logic [1:0] {IDLE, MEAS, REPORT} mon_state_t;
    localparam int CNT_W_DEF   = 8;
    localparam int WIN_LEN_DEF = 16;
    localparam int WIN_W       = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
//   clk, rst (async, active-low) | clear: sync zero, wins over inc | inc: count one | q: count value
module sat_counter
    import sig_mon_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (inc && q != {W{1'b1}})
            q <= q + 1'b1;
endmodule

// File: rtl/sig_edge_monitor.sv
// sig_edge_monitor: counts rising edges, high cycles and blocked cycles of sig_reg over a WIN_LEN-cycle window
//   clk, rst (async, active-low)
//   sig_reg, sig_comb: observed signals | start: open a window (IDLE only) | busy: window in progress
//   rpt_valid/rpt_ready: report handshake | rpt_rise, rpt_high, rpt_blk: saturating window counts
module sig_edge_monitor
    import sig_mon_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_reg,
    input  logic             sig_comb,
    input  logic             start,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_rise,
    output logic [CNT_W-1:0] rpt_high,
    output logic [CNT_W-1:0] rpt_blk
);
    mon_state_t       state, state_nx;
    logic             sig_prev, sig_comb_d;
    logic [WIN_W-1:0] win_cnt;
    logic             clear, meas, last;
    assign meas  = state == MEAS;
    assign clear = state == IDLE && start;
    assign last  = win_cnt == WIN_W'(1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            sig_prev   <= 1'b0;
            sig_comb_d <= 1'b0;
            win_cnt    <= '0;
        end else begin
            state      <= state_nx;
            sig_prev   <= sig_reg;
            sig_comb_d <= sig_comb;
            win_cnt    <= clear ? WIN_W'(WIN_LEN) : meas ? win_cnt - 1'b1 : win_cnt;
        end
    always_comb begin
        state_nx  = state;
        busy      = meas;
        rpt_valid = state == REPORT;
        if (clear)
            state_nx = MEAS;
        else if (meas && last)
            state_nx = REPORT;
        else if (rpt_valid && rpt_ready)
            state_nx = IDLE;
    end
    // counters only move while measuring, so the last report is held through REPORT and IDLE
    sat_counter #(.W(CNT_W)) u_rise (
        .clk(clk), .rst(rst), .clear(clear), .inc(meas & sig_reg & ~sig_prev), .q(rpt_rise)
    );
    sat_counter #(.W(CNT_W)) u_high (
        .clk(clk), .rst(rst), .clear(clear), .inc(meas & sig_reg), .q(rpt_high)
    );
    sat_counter #(.W(CNT_W)) u_blk (
        .clk(clk), .rst(rst), .clear(clear), .inc(meas & sig_reg & ~sig_comb_d), .q(rpt_blk)
    );
endmodule

// File: tb/tb_sig_edge_monitor.sv
// tb_sig_edge_monitor: directed windows with a report scoreboard for a default and a small saturating instance
module tb_sig_edge_monitor;
    typedef struct {int r; int h; int b;} exp_t;
    logic clk, rst;
    logic sig_reg, sig_comb, start, rpt_ready, busy, rpt_valid;
    logic [7:0] rpt_rise, rpt_high, rpt_blk;
    logic sig_reg_b, sig_comb_b, start_b, rpt_ready_b, busy_b, rpt_valid_b;
    logic [3:0] rpt_rise_b, rpt_high_b, rpt_blk_b;
    exp_t q_a[$], q_b[$];
    int total = 0, bad = 0;
    logic pa = 1'b0, pb = 1'b0;

    sig_edge_monitor dut_a (
        .clk(clk), .rst(rst), .sig_reg(sig_reg), .sig_comb(sig_comb), .start(start),
        .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_rise(rpt_rise), .rpt_high(rpt_high), .rpt_blk(rpt_blk)
    );
    sig_edge_monitor #(.CNT_W(4), .WIN_LEN(20)) dut_b (
        .clk(clk), .rst(rst), .sig_reg(sig_reg_b), .sig_comb(sig_comb_b), .start(start_b),
        .busy(busy_b), .rpt_valid(rpt_valid_b), .rpt_ready(rpt_ready_b),
        .rpt_rise(rpt_rise_b), .rpt_high(rpt_high_b), .rpt_blk(rpt_blk_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic win_a(input logic [15:0] pat, input logic comb, input int er, input int eh, input int eb);
        sig_comb = comb;
        sig_reg  = 1'b0;
        start    = 1'b1;
        q_a.push_back('{er, eh, eb});
        cyc();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sig_reg = pat[i];
            if (i == 15) begin
                chk("busy_last_cycle", busy, 1);
                chk("valid_before_end", rpt_valid, 0);
            end
            cyc();
        end
        chk("valid_at_n17", rpt_valid, 1);
        chk("busy_at_n17", busy, 0);
    endtask

    // scoreboard monitor: every new report is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rpt_valid && !pa) begin
                if (q_a.size() == 0)
                    chk("a_unexpected_report", 1, 0);
                else begin
                    e = q_a.pop_front();
                    chk("a_rise", int'(rpt_rise), e.r);
                    chk("a_high", int'(rpt_high), e.h);
                    chk("a_blk", int'(rpt_blk), e.b);
                end
            end
            if (rpt_valid_b && !pb) begin
                if (q_b.size() == 0)
                    chk("b_unexpected_report", 1, 0);
                else begin
                    e = q_b.pop_front();
                    chk("b_rise", int'(rpt_rise_b), e.r);
                    chk("b_high", int'(rpt_high_b), e.h);
                    chk("b_blk", int'(rpt_blk_b), e.b);
                end
            end
            pa = rpt_valid;
            pb = rpt_valid_b;
        end
    end

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            {sig_reg, sig_comb, start, rpt_ready} = 4'($urandom);
            {sig_reg_b, sig_comb_b, start_b, rpt_ready_b} = 4'($urandom);
            cyc();
        end
        chk("rst_busy", busy, 0);
        chk("rst_valid", rpt_valid, 0);
        chk("rst_rise", int'(rpt_rise), 0);
        chk("rst_high", int'(rpt_high), 0);
        chk("rst_blk", int'(rpt_blk), 0);
        chk("rst_valid_b", rpt_valid_b, 0);
        {sig_reg, sig_comb, start, rpt_ready} = 4'b0001;
        {sig_reg_b, sig_comb_b, start_b, rpt_ready_b} = 4'b0001;
        rst = 1'b1;
        cyc();
        chk("idle_busy", busy, 0);

        win_a(16'hAAAA, 1'b1, 8, 8, 0);
        cyc();
        chk("toggle_handoff_valid", rpt_valid, 0);

        win_a(16'hFFFF, 1'b0, 1, 16, 16);
        cyc();

        rpt_ready = 1'b0;
        win_a(16'h0F0F, 1'b0, 2, 8, 8);
        for (int k = 0; k < 5; k++) begin
            start = k == 2;
            chk("bp_valid", rpt_valid, 1);
            chk("bp_busy", busy, 0);
            chk("bp_high", int'(rpt_high), 8);
            chk("bp_blk", int'(rpt_blk), 8);
            cyc();
        end
        rpt_ready = 1'b1;
        start = 1'b1;
        chk("bp_still_valid", rpt_valid, 1);
        cyc();
        start = 1'b0;
        chk("bp_release_valid", rpt_valid, 0);
        chk("bp_release_busy", busy, 0);
        cyc();
        chk("start_at_handoff_ignored", busy, 0);
        chk("idle_hold_high", int'(rpt_high), 8);
        chk("idle_hold_rise", int'(rpt_rise), 2);

        sig_comb = 1'b1;
        sig_reg  = 1'b1;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        chk("mid_window_high", int'(rpt_high), 6);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rpt_valid, 0);
        chk("midrst_rise", int'(rpt_rise), 0);
        chk("midrst_high", int'(rpt_high), 0);
        chk("midrst_blk", int'(rpt_blk), 0);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        win_a(16'h0000, 1'b1, 0, 0, 0);
        cyc();

        sig_comb_b = 1'b1;
        sig_reg_b  = 1'b0;
        start_b    = 1'b1;
        q_b.push_back('{1, 15, 0});
        cyc();
        start_b   = 1'b0;
        sig_reg_b = 1'b1;
        repeat (19) cyc();
        chk("b_valid_before_end", rpt_valid_b, 0);
        cyc();
        chk("b_valid_at_n21", rpt_valid_b, 1);

        repeat (3) cyc();
        chk("a_reports_outstanding", q_a.size(), 0);
        chk("b_reports_outstanding", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
